// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, controller phases and
// the ALU-operation classifier used by the controller and IR decode.
package cpu_pkg;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    // Instructions that read their operand from memory into the ALU.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Fixed 8-phase instruction sequencer; all strobes decode combinationally
// from the registered phase/halted state plus the current opcode and zero flag.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       halt,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr,
    output logic [2:0] phase
);

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   aluop;

    assign aluop = is_aluop(opcode);
    assign phase = phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // A HLT in OP_ADDR latches halted and parks the phase at OP_ADDR.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == OP_ADDR && opcode == HLT) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        halt   = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    if (opcode == HLT) begin
                        halt = 1'b1;
                    end else begin
                        inc_pc = 1'b1;
                    end
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == SKZ) && zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == JMP);
                    wr     = (opcode == STO);
                    data_e = (opcode == STO);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized self-checking bench for cpu_controller with an attached
// behavioural program counter and an instruction-level reference model.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;
    logic [2:0] phase;

    logic [4:0] ir_addr;
    logic [4:0] pc;

    int checks = 0;
    int errors = 0;

    int         mphase;
    bit         mhalted;
    logic [4:0] exp_pc;

    cpu_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .halt   (halt),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    // Program counter as the CPU wires it: sync reset, load beats increment.
    always_ff @(posedge clk) begin
        if (rst)         pc <= '0;
        else if (ld_pc)  pc <= ir_addr;
        else if (inc_pc) pc <= pc + 5'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {sel,rd,ld_ir,inc_pc,ld_pc,halt,data_e,ld_ac,wr}.
    function automatic logic [8:0] expect_out(input int p, input bit h,
                                              input int op, input bit z);
        bit alu, run;
        alu = (op >= 2 && op <= 5);
        run = !h;
        return {run && p <= 3,
                run && ((p >= 1 && p <= 3) || (p >= 5 && alu)),
                run && (p == 2 || p == 3),
                run && ((p == 4 && op != 0) || (p == 6 && op == 1 && z)),
                run && p >= 6 && op == 7,
                h || (p == 4 && op == 0),
                run && p >= 6 && op == 6,
                run && p == 7 && alu,
                run && p == 7 && op == 6};
    endfunction

    task automatic one_cycle();
        @(negedge clk);
        check_eq("strobes", {23'd0, sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr},
                 {23'd0, expect_out(mphase, mhalted, int'(opcode), zero)});
        check_eq("phase", {29'd0, phase}, mphase);
        if (!mhalted) begin
            if (mphase == 4 && opcode == 3'd0) mhalted = 1'b1;
            else mphase = (mphase + 1) % 8;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z, input logic [4:0] a);
        opcode  = op;
        zero    = z;
        ir_addr = a;
        check_eq("pc_start", {27'd0, pc}, {27'd0, exp_pc});
        for (int unsigned c = 0; c < 8; c++) one_cycle();
        case (op)
            3'd0:    ;
            3'd1:    exp_pc = exp_pc + (z ? 5'd2 : 5'd1);
            3'd7:    exp_pc = a;
            default: exp_pc = exp_pc + 5'd1;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_phase", {29'd0, phase}, 0);
        check_eq("rst_strobes", {23'd0, sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr},
                 {23'd0, 9'b1_0000_0000});
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mphase  = 0;
        mhalted = 1'b0;
        exp_pc  = '0;
    endtask

    initial begin
        rst     = 1'b1;
        opcode  = 3'd2;
        zero    = 1'b0;
        ir_addr = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Abort a STO in phase 5.
        opcode = 3'd6;
        zero   = 1'b0;
        for (int unsigned c = 0; c < 5; c++) one_cycle();
        check_eq("pre_rst_phase", {29'd0, phase}, 5);
        #2;
        do_reset();
        check_eq("rst_wr", {31'd0, wr}, 0);
        check_eq("rst_data_e", {31'd0, data_e}, 0);

        run_instr(3'd2, 1'b0, 5'h00);
        run_instr(3'd5, 1'b1, 5'h00);
        run_instr(3'd3, 1'b0, 5'h00);
        run_instr(3'd1, 1'b1, 5'h00);
        check_eq("skz_taken_pc", {27'd0, pc}, 5);
        run_instr(3'd7, 1'b0, 5'h03);
        run_instr(3'd1, 1'b0, 5'h00);
        check_eq("skz_not_taken_pc", {27'd0, pc}, 4);
        run_instr(3'd7, 1'b0, 5'h1A);
        check_eq("jmp_pc", {27'd0, pc}, 32'h1A);
        run_instr(3'd6, 1'b1, 5'h00);
        run_instr(3'd4, 1'b1, 5'h00);

        for (int unsigned i = 0; i < 250; i++) begin
            run_instr(3'($urandom_range(7, 1)), 1'($urandom_range(1, 0)),
                      5'($urandom_range(31, 0)));
        end

        run_instr(3'd0, 1'b0, 5'h00);
        for (int unsigned c = 0; c < 20; c++) begin
            zero   = 1'($urandom_range(1, 0));
            opcode = 3'($urandom_range(7, 0));
            one_cycle();
        end
        check_eq("halted_pc", {27'd0, pc}, {27'd0, exp_pc});
        #2;
        do_reset();
        check_eq("post_halt_halt", {31'd0, halt}, 0);
        for (int unsigned i = 0; i < 20; i++) begin
            run_instr(3'($urandom_range(7, 1)), 1'($urandom_range(1, 0)),
                      5'($urandom_range(31, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction-sequencing controller for the 5-bit-address accumulator CPU. It drives the control strobes consumed by `program_counter` (`ld_pc`, `inc_pc`), the instruction register, the accumulator, memory and the address mux. Every instruction takes a fixed 8-phase cycle. Phase is held in an internal 3-bit state register, and all strobes are decoded from that phase, the current IR opcode and the ALU zero flag.

## Interface
Parameters:
- none (opcode and phase encodings come from `cpu_pkg`)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `opcode`  in  3  opcode field of the instruction register
- `zero`  in  1  accumulator-is-zero flag from the ALU
- `sel`  out  1  address mux select: 1 = PC address, 0 = IR operand address
- `rd`  out  1  memory read enable
- `ld_ir`  out  1  instruction register load
- `inc_pc`  out  1  PC increment strobe
- `ld_pc`  out  1  PC load-from-IR strobe (jump)
- `halt`  out  1  CPU halted indicator
- `data_e`  out  1  accumulator-to-data-bus output enable
- `ld_ac`  out  1  accumulator load
- `wr`  out  1  memory write enable
- `phase`  out  3  current phase, for debug and bench

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP is ADD, AND, XOR or LDA.
- Phases advance 0→1→…→7→0, one per clock, unless halted:
  - INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- Strobe decode. Outputs not listed for a phase are 0.
  - INST_ADDR: `sel`.
  - INST_FETCH: `sel`, `rd`.
  - INST_LOAD: `sel`, `rd`, `ld_ir`.
  - IDLE: `sel`, `rd`, `ld_ir`.
  - OP_ADDR:
    - opcode≠HLT: `inc_pc`.
    - opcode=HLT: `halt`, and no `inc_pc`.
  - OP_FETCH: `rd` if ALUOP.
  - ALU_OP:
    - `rd` if ALUOP.
    - `inc_pc` if SKZ and `zero`=1.
    - `ld_pc` if JMP.
    - `data_e` if STO.
  - STORE:
    - `rd` and `ld_ac` if ALUOP.
    - `ld_pc` if JMP.
    - `wr` and `data_e` if STO.
- Halt:
  - In OP_ADDR with opcode=HLT, the internal `halted` flag sets on the next edge.
  - While halted, phase freezes at OP_ADDR (4), `halt`=1, and every other strobe is 0.
  - Only `rst` clears the halted state.
- `ld_pc` and `inc_pc` are never asserted in the same cycle (PC priority is therefore irrelevant).
- `wr` is never asserted with `rd`. `data_e` precedes `wr` by one phase and is held through it.
- `zero` and `opcode` are sampled combinationally each phase. They must be stable from IDLE onward (IR loaded by the INST_LOAD/IDLE edges).

## Timing
- Outputs are combinational from registered phase/halted plus `opcode`/`zero`. No registered outputs; zero-cycle decode latency.
- Throughput: 8 clocks per instruction, fixed.
- PC effect of a normal instruction: +1 at the end of OP_ADDR.
- SKZ with `zero`=1: +1 more at the end of ALU_OP, for a net +2.
- JMP: PC loaded from the IR address on the ALU_OP and STORE edges (idempotent).
- Reset, effective immediately and asynchronously:
  - phase=0, halted=0.
  - Outputs: `sel`=1, all other strobes 0, `halt`=0.
- Reset mid-instruction aborts it with no further strobes. The first phase-1 edge occurs on the first clock after `rst` deasserts.
- `program_counter` resets synchronously. `rst` must span ≥1 rising `clk` edge for the system to restart at address 0.

## Structure
- `cpu_pkg` holds:
  - opcode localparams (HLT…JMP)
  - phase encoding (INST_ADDR…STORE) as a 3-bit typedef/enum
  - an `is_aluop` helper
- Shared with the ALU and IR decode.
- Single module; no sub-module. The phase counter plus the halted flag is too small to split.

## Test plan
- Reset: assert `rst` mid-phase 5 with opcode=STO → phase=0 and `wr`=`data_e`=0 immediately. Release → phases step 1,2,… on successive edges.
- ADD (opcode=2), `zero`=0, one full cycle:
  - `inc_pc` only in phase 4.
  - `rd` in phases 1–3 and 5–7.
  - `ld_ac` only in phase 7.
  - `ld_pc`=`wr`=0 throughout.
- SKZ (opcode=1):
  - `zero`=1 → `inc_pc` in phases 4 and 6; an attached `program_counter` goes from 3 to 5.
  - Repeat with `zero`=0 → PC goes 3→4.
- JMP (opcode=7) with IR address 5'h1A: `ld_pc` in phases 6 and 7, no `inc_pc` there; PC reads 5'h1A at the start of the next instruction.
- STO (opcode=6): `data_e` in phases 6–7, `wr` only in phase 7, `rd`=0 in phases 5–7.
- HLT (opcode=0):
  - `halt`=1 in phase 4 with no `inc_pc`.
  - Phase stays 4 for 20 clocks with all strobes 0.
  - `rst` pulse → phase=0, `halt`=0.
